// File: rtl/modulo_cursor_matriz.sv
// modulo_cursor_matriz: cursor controller driving the demux column/row pair (mdc/mdl) from five push buttons.
// Ports: clk, rst (async, active-high); btn_up/down/left/right/ok (async, debounced);
//        mdc/mdl current cursor; move_pulse one cycle per cursor change;
//        sel_valid one-cycle confirm strobe with sel_col/sel_row held until the next confirm.
module modulo_cursor_matriz #(
  parameter int COL_MAX       = 4,
  parameter int ROW_MAX       = 4,
  parameter int HOLD_CYCLES   = 25_000_000,
  parameter int REPEAT_CYCLES = 5_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_ok,
  output logic [2:0] mdc,
  output logic [2:0] mdl,
  output logic       move_pulse,
  output logic       sel_valid,
  output logic [2:0] sel_col,
  output logic [2:0] sel_row
);
  localparam int CNT_MAX = HOLD_CYCLES > REPEAT_CYCLES ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int CW = $clog2(CNT_MAX);
  localparam logic [CW-1:0] HOLD_END = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] REP_END = CW'(REPEAT_CYCLES - 1);
  localparam logic [2:0] CM = 3'(COL_MAX);
  localparam logic [2:0] RM = 3'(ROW_MAX);
  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;
  state_t state_q, state_d;
  logic [4:0] btn, s1_q, s2_q, s3_q, rise;
  logic [3:0] dir_lvl;
  logic [1:0] dir_q, dir_d, mv_dir;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] mdc_q, mdc_d, mdl_q, mdl_d, sel_col_q, sel_col_d, sel_row_q, sel_row_d;
  logic move_q, move_d, sel_valid_q, sel_valid_d, mv, ok_acc;
  // bit order: 0 up, 1 down, 2 left, 3 right, 4 ok; index order doubles as priority
  assign btn = {btn_ok, btn_right, btn_left, btn_down, btn_up};
  assign rise = s2_q & ~s3_q;
  assign dir_lvl = s2_q[3:0];
  always_comb begin
    state_d = state_q;
    dir_d = dir_q;
    cnt_d = cnt_q;
    mv = 1'b0;
    mv_dir = dir_q;
    ok_acc = 1'b0;
    case (state_q)
      IDLE: begin
        if (|rise[3:0]) begin
          mv_dir = rise[0] ? 2'd0 : rise[1] ? 2'd1 : rise[2] ? 2'd2 : 2'd3;
          dir_d = mv_dir;
          mv = 1'b1;
          cnt_d = '0;
          state_d = HOLD;
        end else begin
          ok_acc = rise[4];
        end
      end
      HOLD, REPEAT: begin
        // the move on the release edge still happens: decision uses the old s2
        if (!dir_lvl[dir_q]) begin
          state_d = IDLE;
        end else if (cnt_q == (state_q == HOLD ? HOLD_END : REP_END)) begin
          mv = 1'b1;
          cnt_d = '0;
          state_d = REPEAT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    mdl_d = (mv && mv_dir == 2'd0) ? (mdl_q == 3'd0 ? RM : mdl_q - 3'd1) :
            (mv && mv_dir == 2'd1) ? (mdl_q >= RM ? 3'd0 : mdl_q + 3'd1) : mdl_q;
    mdc_d = (mv && mv_dir == 2'd2) ? (mdc_q == 3'd0 ? CM : mdc_q - 3'd1) :
            (mv && mv_dir == 2'd3) ? (mdc_q >= CM ? 3'd0 : mdc_q + 3'd1) : mdc_q;
    move_d = (mdc_d != mdc_q) || (mdl_d != mdl_q);
    sel_valid_d = ok_acc;
    sel_col_d = ok_acc ? mdc_q : sel_col_q;
    sel_row_d = ok_acc ? mdl_q : sel_row_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
      state_q <= IDLE;
      dir_q <= '0;
      cnt_q <= '0;
      mdc_q <= '0;
      mdl_q <= '0;
      move_q <= 1'b0;
      sel_valid_q <= 1'b0;
      sel_col_q <= '0;
      sel_row_q <= '0;
    end else begin
      s1_q <= btn;
      s2_q <= s1_q;
      s3_q <= s2_q;
      state_q <= state_d;
      dir_q <= dir_d;
      cnt_q <= cnt_d;
      mdc_q <= mdc_d;
      mdl_q <= mdl_d;
      move_q <= move_d;
      sel_valid_q <= sel_valid_d;
      sel_col_q <= sel_col_d;
      sel_row_q <= sel_row_d;
    end
  end
  assign mdc = mdc_q;
  assign mdl = mdl_q;
  assign move_pulse = move_q;
  assign sel_valid = sel_valid_q;
  assign sel_col = sel_col_q;
  assign sel_row = sel_row_q;
endmodule
